// File: rtl/fifo_mux_arb_if.sv
// Handshake bundle between the four read FIFOs, the round-robin controller and the downstream sink.
// master = controller side, slave = FIFO/downstream side.
interface fifo_mux_arb_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          empty;
  logic [4*DATA_W-1:0] rd_data;
  logic                out_full;
  logic [3:0]          pop;
  logic                push;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          sel;
  logic                busy;

  modport master (
    input  empty, rd_data, out_full,
    output pop, push, out_data, sel, busy
  );

  modport slave (
    output empty, rd_data, out_full,
    input  pop, push, out_data, sel, busy
  );
endinterface

// File: rtl/fifo_mux_arb.sv
// Round-robin read controller sharing one output channel between four FIFOs, bounded bursts per grant.
// Optional macro ARB_FIXED_PRIO_EN: hold the rotation pointer at 0 (fixed priority, FIFO0 highest).
module fifo_mux_arb #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_mux_arb_if.master    bus
);

  typedef enum logic [1:0] {ARB, POP, CAP} state_t;

  localparam logic [2:0] L_MAX_BURST = 3'(MAX_BURST);

  state_t            r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_sel;
  logic [2:0]        r_cnt;
  logic [DATA_W-1:0] r_outData;
  logic              r_push;

  logic              w_selEmpty;
  logic              w_popEn;
  logic              w_burstEnd;
  logic [1:0]        w_ptrNext;
  logic [1:0]        w_grantIdx;
  logic [DATA_W-1:0] w_capWord;

  // First requester at or after ptr, scanning downward so the smallest offset wins.
  function automatic logic [1:0] pickNext(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    pickNext = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pickNext = idx;
    end
  endfunction

  assign w_grantIdx = pickNext(~bus.empty, r_ptr);
  assign w_selEmpty = bus.empty[r_sel];
  assign w_popEn    = (r_state == POP) && !bus.out_full && !w_selEmpty;
  assign w_burstEnd = ((r_cnt + 3'd1) == L_MAX_BURST) || w_selEmpty;
  assign w_capWord  = bus.rd_data[r_sel*DATA_W +: DATA_W];

`ifdef ARB_FIXED_PRIO_EN
  assign w_ptrNext = 2'd0;
`else
  assign w_ptrNext = r_sel + 2'd1;
`endif

  assign bus.pop      = w_popEn ? (4'b0001 << r_sel) : 4'b0000;
  assign bus.busy     = (r_state != ARB);
  assign bus.push     = r_push;
  assign bus.out_data = r_outData;
  assign bus.sel      = r_sel;

  // Word popped in POP arrives during CAP; it is captured and pushed unconditionally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ARB;
      r_ptr     <= 2'd0;
      r_sel     <= 2'd0;
      r_cnt     <= 3'd0;
      r_outData <= '0;
      r_push    <= 1'b0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        ARB: begin
          if (bus.empty != 4'b1111) begin
            r_sel   <= w_grantIdx;
            r_cnt   <= 3'd0;
            r_state <= POP;
          end
        end
        POP: begin
          if (w_popEn) begin
            r_state <= CAP;
          end else if (w_selEmpty) begin
            r_ptr   <= w_ptrNext;
            r_state <= ARB;
          end
        end
        CAP: begin
          r_outData <= w_capWord;
          r_push    <= 1'b1;
          r_cnt     <= r_cnt + 3'd1;
          if (w_burstEnd) begin
            r_ptr   <= w_ptrNext;
            r_state <= ARB;
          end else begin
            r_state <= POP;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_mux_arb.sv
// Directed bench for fifo_mux_arb: behavioural FIFOs with one-cycle read latency plus a push monitor.
// Follows ARB_FIXED_PRIO_EN when the design is built with it.
module tb_fifo_mux_arb;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst;

  fifo_mux_arb_if #(.DATA_W(DATA_W)) bus();

  fifo_mux_arb #(.DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int fill[4];
  int base[4];
  int popped[4];
  int assertCount = 0;
  int failCount   = 0;
  int cycleCount  = 0;
  logic [DATA_W-1:0] pushData[$];
  int                pushCyc[$];

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // FIFO i holds fill[i] words counting up from base[i]; data appears the cycle after pop.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) popped[i] <= 0;
      bus.rd_data <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bus.pop[i]) begin
          bus.rd_data[i*DATA_W +: DATA_W] <= DATA_W'(base[i] + popped[i]);
          popped[i] <= popped[i] + 1;
        end
      end
    end
  end

  always_comb begin
    bus.empty = 4'b1111;
    for (int i = 0; i < 4; i++) bus.empty[i] = (popped[i] >= fill[i]);
  end

  always @(negedge clk) begin
    if (rst && bus.push) begin
      pushData.push_back(bus.out_data);
      pushCyc.push_back(cycleCount);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input int words, input int firstWord);
    fill[idx] = words;
    base[idx] = firstWord;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    bus.out_full = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(i, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic waitPushes(input int startIdx, input int n, input int maxCycles, input string tag);
    int cyc = 0;
    while ((pushData.size() - startIdx) < n && cyc < maxCycles) begin
      @(posedge clk);
      cyc++;
    end
    if ((pushData.size() - startIdx) < n) checkOutput(tag, 32'(pushData.size() - startIdx), 32'(n));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " pop"},      32'(bus.pop),      32'h0);
    checkOutput({tag, " push"},     32'(bus.push),     32'h0);
    checkOutput({tag, " out_data"}, 32'(bus.out_data), 32'h0);
    checkOutput({tag, " sel"},      32'(bus.sel),      32'h0);
    checkOutput({tag, " busy"},     32'(bus.busy),     32'h0);
  endtask

  initial begin
    int startIdx;
    int used[4];
    int f;

    rst = 1'b0;
    bus.out_full = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(i, 0, 0);
    #1;
    checkIdle("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Random traffic, then asynchronous reset mid-cycle
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) applyStimulus(i, int'($urandom_range(0, 3)), 16 * i + 1);
      bus.out_full = 1'(($urandom_range(0, 1)));
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    checkIdle("midrst");
    for (int i = 0; i < 4; i++) applyStimulus(i, 0, 0);
    bus.out_full = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle busy", 32'(bus.busy), 32'h0);
    checkOutput("idle push", 32'(bus.push), 32'h0);

    // Two words from FIFO1, then grant search resumes at FIFO2
    applyReset();
    applyStimulus(1, 2, 'hA1);
    @(negedge clk);
    checkOutput("t2 sel", 32'(bus.sel), 32'h1);
    checkOutput("t2 busy", 32'(bus.busy), 32'h1);
    checkOutput("t2 pop t", 32'(bus.pop), 32'h2);
    @(negedge clk);
    checkOutput("t2 pop t+1", 32'(bus.pop), 32'h0);
    checkOutput("t2 push t+1", 32'(bus.push), 32'h0);
    @(negedge clk);
    checkOutput("t2 push t+2", 32'(bus.push), 32'h1);
    checkOutput("t2 data A1", 32'(bus.out_data), 32'hA1);
    checkOutput("t2 pop t+2", 32'(bus.pop), 32'h2);
    @(negedge clk);
    checkOutput("t2 push t+3", 32'(bus.push), 32'h0);
    checkOutput("t2 hold A1", 32'(bus.out_data), 32'hA1);
    @(negedge clk);
    checkOutput("t2 push t+4", 32'(bus.push), 32'h1);
    checkOutput("t2 data A2", 32'(bus.out_data), 32'hA2);
    checkOutput("t2 busy end", 32'(bus.busy), 32'h0);
    applyStimulus(0, 1, 'h10);
    applyStimulus(2, 1, 'h20);
    @(negedge clk);
    checkOutput("t2 next sel", 32'(bus.sel), 32'h2);

    // All FIFOs full: 4-word bursts rotating 0,1,2,3,0
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(i, 1000, 64 * i);
    startIdx = pushData.size();
    waitPushes(startIdx, 20, 300, "rr timeout");
    for (int i = 0; i < 4; i++) used[i] = 0;
    for (int k = 0; k < 20; k++) begin
      f = (k / 4) % 4;
      checkOutput($sformatf("rr word %0d", k), 32'(pushData[startIdx + k]), 32'((64 * f + used[f]) % 256));
      used[f]++;
    end
    checkOutput("rr gap in burst", 32'(pushCyc[startIdx + 1] - pushCyc[startIdx]), 32'd2);
    checkOutput("rr gap at grant", 32'(pushCyc[startIdx + 4] - pushCyc[startIdx + 3]), 32'd3);

    // Backpressure held in POP for 5 cycles
    applyReset();
    bus.out_full = 1'b1;
    applyStimulus(2, 1000, 'h80);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp pop %0d", c), 32'(bus.pop), 32'h0);
      checkOutput($sformatf("bp push %0d", c), 32'(bus.push), 32'h0);
    end
    checkOutput("bp sel", 32'(bus.sel), 32'h2);
    checkOutput("bp busy", 32'(bus.busy), 32'h1);
    bus.out_full = 1'b0;
    #1;
    checkOutput("bp release pop", 32'(bus.pop), 32'h4);
    @(negedge clk);
    checkOutput("bp cap push", 32'(bus.push), 32'h0);
    @(negedge clk);
    checkOutput("bp push", 32'(bus.push), 32'h1);
    checkOutput("bp data", 32'(bus.out_data), 32'h80);

    // out_full raised while a word is in CAP
    applyReset();
    applyStimulus(3, 1000, 'hC0);
    @(negedge clk);
    checkOutput("cf pop", 32'(bus.pop), 32'h8);
    @(negedge clk);
    bus.out_full = 1'b1;
    @(negedge clk);
    checkOutput("cf push", 32'(bus.push), 32'h1);
    checkOutput("cf data", 32'(bus.out_data), 32'hC0);
    checkOutput("cf pop held", 32'(bus.pop), 32'h0);
    @(negedge clk);
    checkOutput("cf push low", 32'(bus.push), 32'h0);
    checkOutput("cf pop still held", 32'(bus.pop), 32'h0);
    bus.out_full = 1'b0;
    #1;
    checkOutput("cf resume pop", 32'(bus.pop), 32'h8);
    @(negedge clk);
    checkOutput("cf resume cap", 32'(bus.push), 32'h0);
    @(negedge clk);
    checkOutput("cf second push", 32'(bus.push), 32'h1);
    checkOutput("cf second data", 32'(bus.out_data), 32'hC1);

    // FIFO0 and FIFO2 always busy: alternation, or FIFO0 only under fixed priority
    applyReset();
    applyStimulus(0, 1000, 'h00);
    applyStimulus(2, 1000, 'h80);
    startIdx = pushData.size();
    waitPushes(startIdx, 16, 300, "prio timeout");
    for (int i = 0; i < 4; i++) used[i] = 0;
    for (int k = 0; k < 16; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      f = 0;
`else
      f = ((k / 4) % 2 == 1) ? 2 : 0;
`endif
      checkOutput($sformatf("prio word %0d", k), 32'(pushData[startIdx + k]), 32'((f * 64 + used[f]) % 256));
      used[f]++;
    end
    checkOutput("prio gap at grant", 32'(pushCyc[startIdx + 4] - pushCyc[startIdx + 3]), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
